// File: rtl/lb_cfg_pkg.sv
// lb_cfg_pkg: shared types and constants for the logic-block config controller.
//   state_t           FSM state encoding (IDLE, LOAD, CHECK, COMMIT)
//   MEM_W_DEF         default LUT width (2-input LUT -> 4 bits)
//   N_BLOCKS_DEF      default number of configured blocks
//   frame_len()       payload length in bits: one (mem + sync) record per block
//   trailer_len()     checksum trailer length in bits, 0 unless LB_CFG_CHECKSUM_EN
// Optional feature macro: LB_CFG_CHECKSUM_EN.
package lb_cfg_pkg;

   typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

   localparam int MEM_W_DEF    = 4;
   localparam int N_BLOCKS_DEF = 4;

   function automatic int frame_len(input int n_blocks, input int mem_w);
      return n_blocks * (mem_w + 1);
   endfunction

   function automatic int trailer_len(input int mem_w);
`ifdef LB_CFG_CHECKSUM_EN
      return mem_w;
`else
      return 0 * mem_w;
`endif
   endfunction

   localparam int FRAME_LEN_DEF   = frame_len(N_BLOCKS_DEF, MEM_W_DEF);
   localparam int TRAILER_LEN_DEF = trailer_len(MEM_W_DEF);

endpackage

// File: rtl/lb_cfg_shifter.sv
// lb_cfg_shifter: shadow shift register and payload bit counter.
//   clk, rst   clock and synchronous active-high reset
//   clr        clears the bit counter (frame start)
//   shift_en   accept bit_in this cycle
//   bit_in     serial payload bit
//   shadow     shadow register; the first bit received ends up at index 0
//   last       high on the cycle the final payload bit is accepted
module lb_cfg_shifter
   import lb_cfg_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 shift_en,
   input  logic                 bit_in,
   output logic [FRAME_LEN-1:0] shadow,
   output logic                 last
);

   localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

   logic [FRAME_LEN-1:0] shadow_q, shadow_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;

   assign last   = shift_en && (cnt_q == CNT_W'(FRAME_LEN - 1));
   assign shadow = shadow_q;

   // Shift right with new bits entering at the MSB, so after a full frame
   // block 0's mem LSB sits at bit 0 and each record is MEM_W+1 contiguous bits.
   always_comb begin
      shadow_d = shadow_q;
      cnt_d    = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (shift_en) begin
         shadow_d = {bit_in, shadow_q[FRAME_LEN-1:1]};
         cnt_d    = last ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         cnt_q    <= '0;
      end else begin
         shadow_q <= shadow_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/lb_config_ctrl.sv
// lb_config_ctrl: serial configuration controller for an array of LUT blocks.
//   clk, rst    clock and synchronous active-high reset
//   start       one-cycle pulse, begins a frame (ignored unless IDLE)
//   cfg_valid   serial bit valid; cfg_data serial bit; cfg_ready accept
//   mem_out     committed LUT words, block k at [k*MEM_W +: MEM_W]
//   sync_out    committed per-block sync select
//   busy        frame in progress; done one-cycle commit pulse; err sticky
// Optional feature macro: LB_CFG_CHECKSUM_EN adds a MEM_W-bit XOR trailer
// that must match the XOR of all mem words before the frame is committed.
module lb_config_ctrl
   import lb_cfg_pkg::*;
#(
   parameter int N_BLOCKS = N_BLOCKS_DEF,
   parameter int MEM_W    = MEM_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      start,
   input  logic                      cfg_valid,
   input  logic                      cfg_data,
   output logic                      cfg_ready,
   output logic [N_BLOCKS*MEM_W-1:0] mem_out,
   output logic [N_BLOCKS-1:0]       sync_out,
   output logic                      busy,
   output logic                      done,
   output logic                      err
);

   localparam int FRAME_LEN = frame_len(N_BLOCKS, MEM_W);
   localparam int REC_W     = MEM_W + 1;

   state_t                    state_q, state_d;
   logic [N_BLOCKS*MEM_W-1:0] mem_q, mem_d, mem_sh;
   logic [N_BLOCKS-1:0]       sync_q, sync_d, sync_sh;
   logic                      cfg_ready_q, cfg_ready_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      err_q, err_d;

   logic                      xfer, start_acc, load_en, last;
   logic [FRAME_LEN-1:0]      shadow;

   assign xfer      = cfg_valid && cfg_ready_q;
   assign start_acc = (state_q == IDLE) && start;
   assign load_en   = xfer && (state_q == LOAD);

   lb_cfg_shifter #(.FRAME_LEN(FRAME_LEN)) u_shifter (
      .clk      (clk),
      .rst      (rst),
      .clr      (start_acc),
      .shift_en (load_en),
      .bit_in   (cfg_data),
      .shadow   (shadow),
      .last     (last)
   );

   // Strip the sync bit out of each shadow record.
   always_comb begin
      mem_sh  = '0;
      sync_sh = '0;
      for (int k = 0; k < N_BLOCKS; k++) begin
         mem_sh[k*MEM_W +: MEM_W] = shadow[k*REC_W +: MEM_W];
         sync_sh[k]               = shadow[k*REC_W + MEM_W];
      end
   end

`ifdef LB_CFG_CHECKSUM_EN
   localparam int TCNT_W = (MEM_W > 1) ? $clog2(MEM_W) : 1;

   logic [MEM_W-1:0]  trl_q, trl_d, trl_word, csum;
   logic [TCNT_W-1:0] tcnt_q, tcnt_d;

   always_comb begin
      csum = '0;
      for (int k = 0; k < N_BLOCKS; k++) csum = csum ^ mem_sh[k*MEM_W +: MEM_W];
   end

   // Trailer arrives LSB first; this is the full word once the final bit is in.
   assign trl_word = {cfg_data, trl_q[MEM_W-1:1]};
`endif

   always_comb begin
      state_d = state_q;
      mem_d   = mem_q;
      sync_d  = sync_q;
      err_d   = err_q;
      done_d  = 1'b0;
`ifdef LB_CFG_CHECKSUM_EN
      trl_d   = trl_q;
      tcnt_d  = tcnt_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = LOAD;
               err_d   = 1'b0;
            end
         end
         LOAD: begin
            if (last) state_d = CHECK;
`ifdef LB_CFG_CHECKSUM_EN
            tcnt_d = '0;
`endif
         end
         CHECK: begin
`ifdef LB_CFG_CHECKSUM_EN
            if (xfer) begin
               trl_d = trl_word;
               if (tcnt_q == TCNT_W'(MEM_W - 1)) begin
                  if (trl_word == csum) begin
                     state_d = COMMIT;
                  end else begin
                     state_d = IDLE;
                     err_d   = 1'b1;
                  end
               end else begin
                  tcnt_d = tcnt_q + TCNT_W'(1);
               end
            end
`else
            state_d = COMMIT;
`endif
         end
         COMMIT: begin
            // done is registered with the output words so it asserts on the
            // same cycle the new configuration becomes visible.
            mem_d   = mem_sh;
            sync_d  = sync_sh;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

`ifdef LB_CFG_CHECKSUM_EN
      cfg_ready_d = (state_d == LOAD) || (state_d == CHECK);
`else
      cfg_ready_d = (state_d == LOAD);
`endif
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_q       <= '0;
         sync_q      <= '0;
         cfg_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
`ifdef LB_CFG_CHECKSUM_EN
         trl_q       <= '0;
         tcnt_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         mem_q       <= mem_d;
         sync_q      <= sync_d;
         cfg_ready_q <= cfg_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
`ifdef LB_CFG_CHECKSUM_EN
         trl_q       <= trl_d;
         tcnt_q      <= tcnt_d;
`endif
      end
   end

   assign cfg_ready = cfg_ready_q;
   assign mem_out   = mem_q;
   assign sync_out  = sync_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule

// File: tb/tb_lb_config_ctrl.sv
// Testbench for lb_config_ctrl (N_BLOCKS=4, MEM_W=4). Directed frames; the
// expected commit is queued when a frame is issued and a negedge monitor pops
// it when done is seen. Between commits the monitor checks outputs hold.
// Define LB_CFG_CHECKSUM_EN for both bench and RTL to exercise the trailer.
module tb_lb_config_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, cfg_valid, cfg_data;
   logic        cfg_ready, busy, done, err;
   logic [15:0] mem_out;
   logic [3:0]  sync_out;

   lb_config_ctrl #(.N_BLOCKS(4), .MEM_W(4)) dut (
      .clk(clk), .rst(rst), .start(start), .cfg_valid(cfg_valid),
      .cfg_data(cfg_data), .cfg_ready(cfg_ready), .mem_out(mem_out),
      .sync_out(sync_out), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

`ifdef LB_CFG_CHECKSUM_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   typedef struct { logic [15:0] m; logic [3:0] s; } exp_t;
   exp_t        sb[$];
   logic [15:0] hold_m = '0;
   logic [3:0]  hold_s = '0;
   bit          chk_en = 1'b0;
   int          last_acc = 0;
   int          checks = 0, errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Monitor: commits are compared against the scoreboard; otherwise outputs
   // must keep the last committed value.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (chk_en) begin
         if (done) begin
            if (sb.size() == 0) begin
               check("done_unexpected", {31'd0, done}, 32'd0);
            end else begin
               e = sb.pop_front();
               check("commit_mem", {16'd0, mem_out}, {16'd0, e.m});
               check("commit_sync", {28'd0, sync_out}, {28'd0, e.s});
               check("commit_latency", cyc - last_acc, LAT);
               hold_m = e.m;
               hold_s = e.s;
            end
         end else begin
            check("hold_mem", {16'd0, mem_out}, {16'd0, hold_m});
            check("hold_sync", {28'd0, sync_out}, {28'd0, hold_s});
         end
      end
   end

   task automatic send_bit(input logic b, input logic st);
      int  n;
      bit  acc;
      n   = 0;
      acc = 1'b0;
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = b;
      start     = st;
      while (!acc) begin
         acc = cfg_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         n++;
         if (!acc && n > 50) begin
            check("bit_accept_timeout", 32'(n), 32'd0);
            break;
         end
      end
      last_acc = cyc;
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start     = 1'b1;
      cfg_valid = 1'b0;
      @(posedge clk);
      #1;
      start = 1'b0;
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("ready_after_start", {31'd0, cfg_ready}, 32'd1);
   endtask

   task automatic run_frame(input logic [15:0] m, input logic [3:0] s, input bit gaps,
                            input int st_at, input logic [3:0] flip);
      exp_t        e;
      int          idx;
      logic        bv;
      logic [3:0]  trl;
      e.m = m;
      e.s = s;
`ifdef LB_CFG_CHECKSUM_EN
      if (flip == 4'd0) sb.push_back(e);
`else
      sb.push_back(e);
`endif
      pulse_start();
      idx = 0;
      for (int k = 0; k < 4; k++) begin
         for (int b = 0; b < 5; b++) begin
            bv = (b < 4) ? m[k*4+b] : s[k];
            send_bit(bv, (idx == st_at) ? 1'b1 : 1'b0);
            idx++;
            if (gaps) begin
               @(negedge clk);
               cfg_valid = 1'b0;
            end
         end
      end
`ifdef LB_CFG_CHECKSUM_EN
      trl = m[3:0] ^ m[7:4] ^ m[11:8] ^ m[15:12] ^ flip;
      for (int b = 0; b < 4; b++) begin
         send_bit(trl[b], 1'b0);
         if (gaps) begin
            @(negedge clk);
            cfg_valid = 1'b0;
         end
      end
`else
      trl = flip;
`endif
      @(negedge clk);
      cfg_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("busy_after_frame", {31'd0, busy}, 32'd0);
      check("err_after_frame", {31'd0, err}, (trl != 4'd0 && flip != 4'd0) ? 32'd1 : 32'd0);
   endtask

   task automatic do_reset(input logic with_start);
      chk_en = 1'b0;
      @(negedge clk);
      rst       = 1'b1;
      start     = with_start;
      cfg_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem", {16'd0, mem_out}, 32'd0);
      check("rst_sync", {28'd0, sync_out}, 32'd0);
      check("rst_ready", {31'd0, cfg_ready}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      rst   = 1'b0;
      start = 1'b0;
      hold_m = '0;
      hold_s = '0;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog_timeout actual=%0d required=finish", cyc);
      $fatal(1, "simulation did not finish");
   end

   initial begin
      rst = 1'b1; start = 1'b0; cfg_valid = 1'b0; cfg_data = 1'b0;
      do_reset(1'b0);

      // cfg_valid in IDLE must be ignored.
      @(negedge clk);
      cfg_valid = 1'b1;
      cfg_data  = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_valid_ignored", {31'd0, busy}, 32'd0);

      // Blocks: AND, OR, XOR, AND; sync 0,1,0,1.
      run_frame(16'h86E8, 4'b1010, 1'b0, -1, 4'd0);
      // Different frame with a stray start in the middle of LOAD.
      run_frame(16'hF421, 4'b0011, 1'b0, 6, 4'd0);
      // Original frame again with valid gaps every other cycle.
      run_frame(16'h86E8, 4'b1010, 1'b1, -1, 4'd0);

      // Partial frame aborted by reset (asserted together with start).
      pulse_start();
      for (int i = 0; i < 7; i++) send_bit(i[0], 1'b0);
      do_reset(1'b1);
      run_frame(16'hF421, 4'b0011, 1'b0, -1, 4'd0);

`ifdef LB_CFG_CHECKSUM_EN
      run_frame(16'h86E8, 4'b1010, 1'b0, -1, 4'd0);
      run_frame(16'hF421, 4'b0011, 1'b0, -1, 4'b0010);
      run_frame(16'hF421, 4'b0011, 1'b1, -1, 4'd0);
`endif

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lb_config_ctrl.md
LB_CONFIG_CTRL -- requirements
Module: lb_config_ctrl

Interface
REQ-001 SHALL have parameter N_BLOCKS, default 4: number of logic blocks configured.
REQ-002 SHALL have parameter MEM_W, default 4: LUT config bits per block (2-input LUT).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  one-cycle pulse that begins a configuration frame.
REQ-006 SHALL have port cfg_valid  input  1  serial config bit valid.
REQ-007 SHALL have port cfg_data  input  1  serial config bit.
REQ-008 SHALL have port cfg_ready  output  1  controller accepts a bit this cycle.
REQ-009 SHALL have port mem_out  output  N_BLOCKS*MEM_W  committed LUT words; block k at [k*MEM_W +: MEM_W].
REQ-010 SHALL have port sync_out  output  N_BLOCKS  committed per-block sync (registered-output select).
REQ-011 SHALL have port busy  output  1  frame in progress.
REQ-012 SHALL have port done  output  1  one-cycle pulse on successful commit.
REQ-013 SHALL have port err  output  1  sticky frame error flag.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, CHECK, COMMIT.
REQ-015 IDLE -> LOAD on start; start in any other state SHALL be ignored.
REQ-016 A bit SHALL transfer only on cycles with cfg_valid && cfg_ready; cfg_ready SHALL be 1 exactly in LOAD.
REQ-017 Frame payload SHALL be N_BLOCKS records of MEM_W+1 bits, block 0 first; per record mem bits LSB first, then sync bit.
REQ-018 Accepted bits SHALL shift into shadow registers; mem_out/sync_out SHALL hold the previous committed values throughout LOAD and CHECK.
REQ-019 Bit counter SHALL count 0..FRAME_LEN-1 and clear on entry to LOAD; LOAD -> CHECK on the cycle the last payload bit is accepted.
REQ-020 CHECK SHALL last one cycle when the checksum feature is compiled out; otherwise it SHALL accept MEM_W further bits (REQ-030).
REQ-021 COMMIT SHALL copy shadow into mem_out/sync_out, pulse done for exactly that one cycle, and return to IDLE; latency from last accepted bit to outputs visible SHALL be 2 cycles (no checksum).
REQ-022 busy SHALL be 1 in LOAD, CHECK, COMMIT; 0 in IDLE.
REQ-023 err SHALL clear on an accepted start and set on a checksum mismatch; on mismatch FSM SHALL go CHECK -> IDLE without committing and without done.
REQ-024 cfg_valid gaps during LOAD SHALL stall the counter with no timeout; cfg_valid outside LOAD SHALL be ignored.

Reset
REQ-025 rst SHALL force IDLE, clear counter and shadow, and set mem_out=0, sync_out=0, cfg_ready=0, busy=0, done=0, err=0.
REQ-026 rst asserted mid-frame SHALL discard the partial frame; rst SHALL take priority over start in the same cycle.

Configuration
REQ-027 Macro LB_CFG_CHECKSUM_EN SHALL enable frame checksum checking.
REQ-028 With LB_CFG_CHECKSUM_EN defined, a MEM_W-bit trailer (LSB first) SHALL follow the payload, accepted in CHECK with the same handshake.
REQ-029 Checksum SHALL be the XOR of all N_BLOCKS mem words (sync bits excluded); match -> COMMIT, mismatch -> REQ-023.
REQ-030 Without the macro, no trailer SHALL be consumed, err SHALL stay 0, and CHECK SHALL unconditionally go to COMMIT.

Structure
REQ-031 Package lb_cfg_pkg SHALL hold the FSM state typedef, MEM_W default and FRAME_LEN/trailer-length constants.
REQ-032 Shadow shift register plus bit counter SHALL be sub-module lb_cfg_shifter; FSM, checksum and commit registers stay in lb_config_ctrl.

Verification
REQ-033 Reset: rst=1 two cycles -> all outputs 0, cfg_ready=0.
REQ-034 N_BLOCKS=4 frame setting blocks to AND 1000, OR 1110, XOR 0110, sync 0,1,0,1 (no gaps) -> mem_out=0x6E8 in bits [11:0] and 1000 in [15:12] order per REQ-009, sync_out=4'b1010, done pulses once, 2 cycles after last bit.
REQ-035 Same frame with cfg_valid deasserted every other cycle -> identical result; mem_out unchanged until COMMIT cycle.
REQ-036 rst pulsed after 7 accepted bits, then full new frame -> outputs 0 after reset, new frame committed correctly.
REQ-037 LB_CFG_CHECKSUM_EN: correct trailer -> commit, err=0; trailer with one bit flipped -> no done, err=1, mem_out retains prior value.
REQ-038 start asserted during LOAD -> ignored, counter continues, frame completes normally.
